chunked_adder_seq: RTL

Multi-cycle, parametrised successor to the team's fixed-width ripple adders. It adds two WIDTH-bit operands plus carry-in by processing one CHUNK-bit slice per clock through a single shared ripple slice. This trades latency for area. It sits between producer and consumer blocks on valid/ready handshakes, for datapaths where a full-width combinational carry chain does not meet timing or area budgets.

---
 rtl/chunked_adder_pkg.sv | 24 ++
 rtl/chunked_adder_seq_if.sv | 42 ++++
 rtl/chunked_adder_seq_chunk.sv | 41 ++++
 rtl/chunked_adder_seq.sv | 116 +++++++++++
 4 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
// The optional subtract path is enabled by defining CHUNK_ADDER_SUB_EN.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice configuration still needs a 1-bit counter to be legal.
    function automatic int calc_cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width > 0) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunked_adder_seq_if.sv
// Operand/result handshake bundle for chunked_adder_seq.
// The sub select exists only when CHUNK_ADDER_SUB_EN is defined.
interface chunked_adder_seq_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
`ifdef CHUNK_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef CHUNK_ADDER_SUB_EN
    modport master (
        output in_valid, in1, in2, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, in1, in2, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`else
    modport master (
        output in_valid, in1, in2, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, in1, in2, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface

// File: rtl/chunked_adder_seq_chunk.sv
// CHUNK-bit ripple slice built from the 1-bit full adder cell; the sequential
// adder reuses one of these for every slice of the operands.
module full_adder_1 (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = in1 ^ in2 ^ cin;
    assign cout = (in1 & in2) | (cin & (in1 ^ in2));

endmodule

module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] in1,
    input  logic [CHUNK-1:0] in2,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[CHUNK];

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder_1 u_fa (
            .in1  (in1[i]),
            .in2  (in2[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder: one CHUNK-bit slice per clock through a shared ripple slice.
// Defining CHUNK_ADDER_SUB_EN adds the sub port (in1 - in2 via ~in2 and carry 1).
module chunked_adder_seq
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic              clk,
    input logic              rst_n,
    chunked_adder_seq_if.slave bus
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CW     = calc_cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
        $error("chunked_adder_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_s;
    logic             slice_c;

    assign slice_a = op_a[cnt*CHUNK +: CHUNK];
    assign slice_b = op_b[cnt*CHUNK +: CHUNK];

    adder_chunk #(.CHUNK(CHUNK)) u_slice (
        .in1  (slice_a),
        .in2  (slice_b),
        .cin  (carry),
        .sum  (slice_s),
        .cout (slice_c)
    );

    // Handshake flags are registered alongside the state so neither depends
    // combinationally on in_valid or out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a <= bus.in1;
`ifdef CHUNK_ADDER_SUB_EN
                        if (bus.sub) begin
                            op_b  <= ~bus.in2;
                            carry <= 1'b1;
                        end else begin
                            op_b  <= bus.in2;
                            carry <= bus.cin;
                        end
`else
                        op_b  <= bus.in2;
                        carry <= bus.cin;
`endif
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_r[cnt*CHUNK +: CHUNK] <= slice_s;
                    carry                     <= slice_c;
                    if (cnt == LAST) begin
                        cout_r      <= slice_c;
                        cnt         <= '0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;

endmodule
